// File: rtl/cc_unit.sv
// Y86-64 execute-stage condition-code register (ZF/SF/OF) and jXX/cmovXX
// condition evaluator. cnd looks only at the latched flags, never at alu_out.
module cc_unit #(
  parameter int unsigned WIDTH  = 64,
  parameter logic [2:0]  RST_CC = 3'b100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_ovf,
  input  logic             set_cc_req,
  input  logic             exc_block,
  input  logic             stall,
  input  logic [3:0]       ifun,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of,
  output logic             cnd,
  output logic             cc_upd
);

  logic upd;
  logic zf_d, sf_d, of_d, upd_d;
  logic zf_q, sf_q, of_q, upd_q;
  logic lt;

  // An exception further down the pipe or an E-stage hold suppresses the write.
  assign upd = set_cc_req & ~exc_block & ~stall;

  always_comb begin
    zf_d  = zf_q;
    sf_d  = sf_q;
    of_d  = of_q;
    upd_d = upd;
    if (upd) begin
      zf_d = (alu_out == '0);
      sf_d = alu_out[WIDTH-1];
      of_d = alu_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zf_q  <= RST_CC[2];
      sf_q  <= RST_CC[1];
      of_q  <= RST_CC[0];
      upd_q <= 1'b0;
    end else begin
      zf_q  <= zf_d;
      sf_q  <= sf_d;
      of_q  <= of_d;
      upd_q <= upd_d;
    end
  end

  assign lt = sf_q ^ of_q;

  always_comb begin
    cnd = 1'b0;
    case (ifun)
      4'd0:    cnd = 1'b1;
      4'd1:    cnd = lt | zf_q;
      4'd2:    cnd = lt;
      4'd3:    cnd = zf_q;
      4'd4:    cnd = ~zf_q;
      4'd5:    cnd = ~lt;
      4'd6:    cnd = ~lt & ~zf_q;
      default: cnd = 1'b0;
    endcase
  end

  assign cc_zf  = zf_q;
  assign cc_sf  = sf_q;
  assign cc_of  = of_q;
  assign cc_upd = upd_q;

endmodule
